// File: rtl/shift_pack.sv
// Four-lane 3-bit symbol packer: accumulates six symbols per lane into 18-bit words,
// first symbol in [2:0]; a flush emits a right-justified, zero-padded partial word.
module shift_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sym_in,
  input  logic        sym_valid,
  output logic        sym_ready,
  input  logic        flush,
  output logic [17:0] buffer1_o,
  output logic [17:0] buffer2_o,
  output logic [17:0] buffer3_o,
  output logic [17:0] buffer4_o,
  output logic [2:0]  word_len,
  output logic        word_valid,
  input  logic        word_ready
);

  localparam int SYM_W = 3;
  localparam int LANES = 4;

  logic [17:0] r_acc [LANES];
  logic [17:0] r_buf [LANES];
  logic [2:0]  r_cnt;
  logic [2:0]  r_len;
  logic        r_word_valid;

  logic        w_slot_free;
  logic        w_sym_acc;
  logic        w_flush_acc;
  logic        w_emit;
  logic [2:0]  w_k;
  logic [4:0]  w_sh_amt;
  logic [17:0] w_shift [LANES];
  logic [17:0] w_word  [LANES];

  assign w_slot_free = !r_word_valid || word_ready;
  assign sym_ready   = w_slot_free || (r_cnt < 3'd5 && !flush);
  assign w_sym_acc   = sym_valid && sym_ready;
  assign w_flush_acc = flush && w_slot_free;
  assign w_k         = r_cnt + {2'b00, w_sym_acc};
  // A symbol at cnt == 5 is only accepted when the slot is free, so no full word is ever lost.
  assign w_emit      = (w_sym_acc && r_cnt == 3'd5) || (w_flush_acc && w_k != 3'd0);

  // Right-justify k held symbols: shift down by 3*(6-k).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_sh_amt = 5'd0;
    case (w_k)
      3'd1:    w_sh_amt = 5'd15;
      3'd2:    w_sh_amt = 5'd12;
      3'd3:    w_sh_amt = 5'd9;
      3'd4:    w_sh_amt = 5'd6;
      3'd5:    w_sh_amt = 5'd3;
      default: w_sh_amt = 5'd0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_shift[i] = {sym_in[SYM_W*i +: SYM_W], r_acc[i][17:3]};
      w_word[i]  = (w_sym_acc ? w_shift[i] : r_acc[i]) >> w_sh_amt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      for (int i = 0; i < LANES; i++) begin
        r_acc[i] <= '0;
        r_buf[i] <= '0;
      end
      r_cnt        <= '0;
      r_len        <= '0;
      r_word_valid <= 1'b0;
    end else if (w_emit) begin
      for (int i = 0; i < LANES; i++) begin
        r_acc[i] <= '0;
        r_buf[i] <= w_word[i];
      end
      r_cnt        <= '0;
      r_len        <= w_k;
      r_word_valid <= 1'b1;
    end else begin
      if (w_sym_acc) begin
        for (int i = 0; i < LANES; i++) r_acc[i] <= w_shift[i];
        r_cnt <= r_cnt + 3'd1;
      end
      if (r_word_valid && word_ready) r_word_valid <= 1'b0;
    end
  end

  assign buffer1_o  = r_buf[0];
  assign buffer2_o  = r_buf[1];
  assign buffer3_o  = r_buf[2];
  assign buffer4_o  = r_buf[3];
  assign word_len   = r_len;
  assign word_valid = r_word_valid;

endmodule

// File: tb/tb_shift_pack.sv
// Directed bench for shift_pack: a vector table for single-word cases plus
// hand-written backpressure, streaming and asynchronous reset sequences.
module tb_shift_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] sym_in;
  logic        sym_valid;
  logic        sym_ready;
  logic        flush;
  logic [17:0] buffer1_o, buffer2_o, buffer3_o, buffer4_o;
  logic [2:0]  word_len;
  logic        word_valid;
  logic        word_ready;

  int n_vec = 0;
  int n_err = 0;

  shift_pack dut (
    .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .flush(flush),
    .buffer1_o(buffer1_o), .buffer2_o(buffer2_o), .buffer3_o(buffer3_o), .buffer4_o(buffer4_o),
    .word_len(word_len), .word_valid(word_valid), .word_ready(word_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] sym;
    logic        vld;
    logic        fl;
    logic        wr;
    logic        exp_rdy;
    logic        exp_wv;
    logic [17:0] exp_b [4];
    logic [2:0]  exp_len;
  } vec_t;

  vec_t vecs [18];

  function automatic logic [11:0] mk(input logic [2:0] l1, l2, l3, l4);
    return {l4, l3, l2, l1};
  endfunction

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0o, want %0o (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [11:0] s, input logic v, input logic f, input logic wr);
    sym_in = s; sym_valid = v; flush = f; word_ready = wr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic wv, input logic [17:0] b1,
                            input logic [17:0] b2, input logic [17:0] b3,
                            input logic [17:0] b4, input logic [2:0] len);
    check({tag, ".word_valid"}, 18'(word_valid), 18'(wv));
    check({tag, ".buffer1"}, buffer1_o, b1);
    check({tag, ".buffer2"}, buffer2_o, b2);
    check({tag, ".buffer3"}, buffer3_o, b3);
    check({tag, ".buffer4"}, buffer4_o, b4);
    check({tag, ".word_len"}, 18'(word_len), 18'(len));
  endtask

  function automatic vec_t mv(input logic [11:0] s, input logic v, input logic f, input logic wr,
                              input logic rdy, input logic wv, input logic [17:0] b1,
                              input logic [17:0] b2, input logic [17:0] b3,
                              input logic [17:0] b4, input logic [2:0] len);
    vec_t r;
    r.sym = s; r.vld = v; r.fl = f; r.wr = wr; r.exp_rdy = rdy; r.exp_wv = wv;
    r.exp_b[0] = b1; r.exp_b[1] = b2; r.exp_b[2] = b3; r.exp_b[3] = b4; r.exp_len = len;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] exp_b [4];
    logic [2:0]  v;

    // Full word, lane1 = 1..6, other lanes 7
    for (int i = 0; i < 5; i++)
      vecs[i] = mv(mk(3'(i + 1), 3'd7, 3'd7, 3'd7), 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mv(mk(3'd6, 3'd7, 3'd7, 3'd7), 1, 0, 1, 1, 1,
                  18'o654321, 18'o777777, 18'o777777, 18'o777777, 3'd6);
    vecs[6]  = mv(12'd0, 0, 0, 1, 1, 0, 18'o654321, 18'o777777, 18'o777777, 18'o777777, 3'd6);
    // Flush partial after two symbols
    vecs[7]  = mv(mk(3'd5, 3'd1, 3'd7, 3'd0), 1, 0, 1, 1, 0,
                  18'o654321, 18'o777777, 18'o777777, 18'o777777, 3'd6);
    vecs[8]  = mv(mk(3'd3, 3'd2, 3'd0, 3'd6), 1, 0, 1, 1, 0,
                  18'o654321, 18'o777777, 18'o777777, 18'o777777, 3'd6);
    vecs[9]  = mv(12'd0, 0, 1, 1, 1, 1, 18'o000035, 18'o000021, 18'o000007, 18'o000060, 3'd2);
    // Flush with nothing held: no new word
    vecs[10] = mv(12'd0, 0, 1, 1, 1, 0, 18'o000035, 18'o000021, 18'o000007, 18'o000060, 3'd2);
    vecs[11] = mv(12'd0, 0, 1, 1, 1, 0, 18'o000035, 18'o000021, 18'o000007, 18'o000060, 3'd2);
    // Three symbols, then a fourth together with flush
    for (int i = 0; i < 3; i++)
      vecs[12 + i] = mv(mk(3'(i + 1), 3'd0, 3'd7, 3'd2), 1, 0, 1, 1, 0,
                        18'o000035, 18'o000021, 18'o000007, 18'o000060, 3'd2);
    vecs[15] = mv(mk(3'd4, 3'd0, 3'd7, 3'd2), 1, 1, 1, 1, 1,
                  18'o004321, 18'o000000, 18'o007777, 18'o002222, 3'd4);
    // One symbol plus flush proves cnt restarted at 0; loads over the draining word
    vecs[16] = mv(mk(3'd5, 3'd6, 3'd1, 3'd3), 1, 1, 1, 1, 1,
                  18'o000005, 18'o000006, 18'o000001, 18'o000003, 3'd1);
    vecs[17] = mv(12'd0, 0, 0, 1, 1, 0, 18'o000005, 18'o000006, 18'o000001, 18'o000003, 3'd1);

    rst_n = 1'b0;
    drive(12'd0, 0, 0, 1);
    #10;
    check("reset.sym_ready", 18'(sym_ready), 18'd1);
    check_word("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[n]) begin
      drive(vecs[n].sym, vecs[n].vld, vecs[n].fl, vecs[n].wr);
      check($sformatf("vec%0d.sym_ready", n), 18'(sym_ready), 18'(vecs[n].exp_rdy));
      tick();
      check_word($sformatf("vec%0d", n), vecs[n].exp_wv, vecs[n].exp_b[0], vecs[n].exp_b[1],
                 vecs[n].exp_b[2], vecs[n].exp_b[3], vecs[n].exp_len);
    end

    // Backpressure: word A, then word B streamed while A is held
    for (int i = 0; i < 6; i++) begin
      drive(mk(3'(i + 1), 3'd0, 3'd0, 3'd0), 1, 0, 0);
      tick();
    end
    check_word("bp.A", 1, 18'o654321, 0, 0, 0, 6);
    for (int i = 0; i < 6; i++) begin
      drive(mk(3'(7 - i), 3'd1, 3'd0, 3'd0), 1, 0, 0);
      check($sformatf("bp.B%0d.sym_ready", i), 18'(sym_ready), (i < 5) ? 18'd1 : 18'd0);
      tick();
      check_word($sformatf("bp.B%0d.hold", i), 1, 18'o654321, 0, 0, 0, 6);
    end
    drive(mk(3'd2, 3'd1, 3'd0, 3'd0), 1, 0, 0);
    tick();
    check_word("bp.stall", 1, 18'o654321, 0, 0, 0, 6);
    drive(mk(3'd2, 3'd1, 3'd0, 3'd0), 1, 0, 1);
    check("bp.release.sym_ready", 18'(sym_ready), 18'd1);
    tick();
    check_word("bp.B", 1, 18'o234567, 18'o111111, 0, 0, 6);
    drive(12'd0, 0, 0, 1);
    tick();
    check("bp.drained", 18'(word_valid), 18'd0);

    // Back-to-back streaming: 24 sets, lane n value = (index + n) mod 8
    for (int j = 0; j < 24; j++) begin
      drive(mk(3'(j % 8), 3'((j + 1) % 8), 3'((j + 2) % 8), 3'((j + 3) % 8)), 1, 0, 1);
      check($sformatf("stream%0d.sym_ready", j), 18'(sym_ready), 18'd1);
      tick();
      if (j % 6 == 5) begin
        for (int n = 0; n < 4; n++) begin
          exp_b[n] = '0;
          for (int i = 0; i < 6; i++) begin
            v = 3'((j - 5 + i + n) % 8);
            exp_b[n] = exp_b[n] | (18'(v) << (3 * i));
          end
        end
        check_word($sformatf("stream%0d", j), 1, exp_b[0], exp_b[1], exp_b[2], exp_b[3], 6);
      end else begin
        check($sformatf("stream%0d.word_valid", j), 18'(word_valid), 18'd0);
      end
    end

    // Asynchronous reset mid-stream with a word pending and a partial accumulation
    for (int i = 0; i < 8; i++) begin
      drive(mk(3'd7, 3'd7, 3'd7, 3'd7), 1, 0, 0);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_word("async_rst", 0, 0, 0, 0, 0, 0);
    check("async_rst.sym_ready", 18'(sym_ready), 18'd1);
    drive(12'd0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(mk(3'd3, 3'd4, 3'd5, 3'd6), 1, 1, 1);
    check("post_rst.sym_ready", 18'(sym_ready), 18'd1);
    tick();
    check_word("post_rst", 1, 18'o000003, 18'o000004, 18'o000005, 18'o000006, 1);
    drive(12'd0, 0, 0, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
